// File: rtl/cbus_mem_responder_if.sv
// cbus_mem_responder_if: cbus request/response types and the cbus bundle with initiator/responder views
package cbus_pkg;
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        mlen_t       len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

interface cbus_if;
    import cbus_pkg::*;
    cbus_req_t  req;
    cbus_resp_t resp;
    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: cbus responder over a word-addressed RAM with wrapping bursts; CBUS_RESP_STALL_EN adds random one-cycle beat stalls
module cbus_mem_responder #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  logic  clk,
    input  logic  resetn,
    cbus_if.slave cbus
);
    typedef enum logic [1:0] {IDLE, WAIT, BURST, TURN} state_t;
    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] word_q, len_w, beat_w;
    logic [3:0]           len_q, cnt_q, wait_q;
    logic                 wr_q, accept, ready, last, stall;
    logic [31:0]          mem_q [DEPTH];
    logic                 unused_bits;

    assign unused_bits = ^{cbus.req.size, cbus.req.addr[31:ADDR_BITS+2], cbus.req.addr[1:0]};
    assign accept      = state_q == IDLE && cbus.req.valid;
    assign len_w       = ADDR_BITS'(len_q);
    assign beat_w      = (word_q & ~len_w) | ((word_q + ADDR_BITS'(cnt_q)) & len_w);
    assign ready       = state_q == BURST && !stall;
    assign last        = ready && cnt_q == len_q;

`ifdef CBUS_RESP_STALL_EN
    logic [7:0] lfsr_q;
    logic       stall_q;
    assign stall = stall_q;
    // free-running LFSR; a non-final beat is followed by one stall when lfsr[0] is set, so stalls never pair up
    always_ff @(posedge clk)
        if (!resetn) begin
            lfsr_q  <= 8'hA5;
            stall_q <= 1'b0;
        end else begin
            lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            stall_q <= ready && !last && lfsr_q[0];
        end
`else
    assign stall = 1'b0;
`endif

    // state register
    always_ff @(posedge clk)
        state_q <= !resetn ? IDLE : state_d;

    // next state and response: accept in IDLE, wait out latency, stream beats, one TURN cycle to let valid drop
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cbus.req.valid ? (LATENCY == 0 ? BURST : WAIT) : IDLE;
            WAIT:    state_d = wait_q == LAT_LAST ? BURST : WAIT;
            BURST:   state_d = last ? TURN : BURST;
            default: state_d = IDLE;
        endcase
        cbus.resp.ready = ready;
        cbus.resp.last  = last;
        cbus.resp.data  = ready ? mem_q[beat_w] : 32'd0;
    end

    // request fields are frozen at accept; latency and beat counters
    always_ff @(posedge clk)
        if (!resetn) begin
            word_q <= '0;
            len_q  <= '0;
            wr_q   <= 1'b0;
            cnt_q  <= '0;
            wait_q <= '0;
        end else begin
            if (accept) begin
                word_q <= cbus.req.addr[ADDR_BITS+1:2];
                len_q  <= cbus.req.len;
                wr_q   <= cbus.req.is_write;
            end
            wait_q <= state_q == WAIT ? wait_q + 4'd1 : 4'd0;
            cnt_q  <= accept || last ? 4'd0 : cnt_q + {3'd0, ready};
        end

    // byte-strobed write with live data/strobe on every ready beat of a write burst
    always_ff @(posedge clk)
        if (resetn && ready && wr_q)
            for (int i = 0; i < 4; i++)
                if (cbus.req.strobe[i]) mem_q[beat_w][8*i +: 8] <= cbus.req.data[8*i +: 8];
endmodule

// File: tb/tb_cbus_mem_responder.sv
// tb_cbus_mem_responder: random and directed bursts against a word-array model, checked by a queue-fed monitor
module tb_cbus_mem_responder;
    import cbus_pkg::*;
    localparam int AB = 8, LAT = 2, DEPTH = 1 << AB;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        bit          last;
    } beat_t;

    logic        clk = 0, resetn = 0;
    beat_t       exp_q[$];
    logic [31:0] model [DEPTH];
    logic [31:0] wbuf [16];
    logic [3:0]  lens [5] = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd15};
    int          checks = 0, fails = 0;
    bit          held = 0;

    cbus_if bus();
    cbus_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (.clk(clk), .resetn(resetn), .cbus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        fails++;
        $display("FAIL %s: got timeout or unexpected beat, want none", name);
    endtask

    always @(negedge clk) begin : mon
        beat_t e;
        if (resetn) begin
            if (bus.resp.ready) begin
                if (exp_q.size() == 0) flag("unexpected_beat");
                else begin
                    e = exp_q.pop_front();
                    chk("beat_last", bus.resp.last, e.last);
                    if (e.rd) chk("rd_data", bus.resp.data, e.data);
                end
            end else begin
                chk("idle_data", bus.resp.data, 32'd0);
                chk("idle_last", bus.resp.last, 0);
            end
        end
    end

    task automatic burst(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                         input logic [3:0] strb, input bit hold, input int abort_at);
        int    beats, w, bw, n;
        bit    was_held;
        beat_t e;
        was_held = held;
        beats = int'(len) + 1;
        w = int'((addr >> 2) % DEPTH);
        for (int b = 0; b < beats; b++) begin
            bw = w - (w % beats) + (w % beats + b) % beats;
            if (wr)
                for (int i = 0; i < 4; i++)
                    if (strb[i]) model[bw][8*i +: 8] = wbuf[b][8*i +: 8];
            e.rd = !wr;
            e.data = model[bw];
            e.last = (b == beats - 1);
            if (abort_at < 0 || b <= abort_at) exp_q.push_back(e);
        end
        if (!was_held) begin
            repeat (2 + $urandom_range(0, 2)) @(negedge clk);
            #1;
        end
        bus.req.valid = 1;
        bus.req.is_write = wr;
        bus.req.size = 3'd2;
        bus.req.addr = addr;
        bus.req.len = mlen_t'(len);
        bus.req.strobe = strb;
        bus.req.data = wbuf[0];
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!bus.resp.ready && n < 40);
        chk("first_beat_latency", n, was_held ? LAT + 3 : LAT + 1);
        if (!bus.resp.ready) begin
            bus.req.valid = 0;
            held = 0;
            exp_q.delete();
            return;
        end
        for (int b = 0; b < beats; b++) begin
            if (b > 0) begin
                n = 0;
                do begin @(negedge clk); #1; n++; end while (!bus.resp.ready && n < 4);
                if (!bus.resp.ready) begin
                    flag("beat_timeout");
                    bus.req.valid = 0;
                    held = 0;
                    exp_q.delete();
                    return;
                end
                chk("beat_gap", n, 1);
            end
            if (b == abort_at) begin
                resetn = 0;
                exp_q.delete();
                @(negedge clk); #1;
                chk("abort_ready", bus.resp.ready, 0);
                chk("abort_last", bus.resp.last, 0);
                chk("abort_data", bus.resp.data, 32'd0);
                bus.req.valid = 0;
                @(negedge clk); #1;
                resetn = 1;
                held = 0;
                return;
            end
            @(posedge clk); #1;
            if (b < beats - 1) bus.req.data = wbuf[b + 1];
        end
        chk("beats_all_seen", exp_q.size(), 0);
        if (!hold) bus.req.valid = 0;
        held = hold;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit wr, hold;
        bus.req = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready", bus.resp.ready, 0);
        chk("reset_last", bus.resp.last, 0);
        chk("reset_data", bus.resp.data, 32'd0);
        resetn = 1;
        for (int i = 0; i < DEPTH / 16; i++) begin
            for (int b = 0; b < 16; b++) wbuf[b] = $urandom;
            burst(1, 32'(i * 64), 4'd15, 4'hF, 0, -1);
        end
        wbuf[0] = 32'hDEADBEEF;
        burst(1, 32'h14, 4'd0, 4'hF, 0, -1);
        burst(0, 32'h14, 4'd0, 4'h0, 0, -1);
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
        burst(1, 32'h20, 4'd3, 4'hF, 0, -1);
        burst(0, 32'h28, 4'd3, 4'h0, 0, -1);
        wbuf[0] = 32'h11223344;
        burst(1, 32'h0C, 4'd0, 4'hF, 0, -1);
        wbuf[0] = 32'hAABBCCDD;
        burst(1, 32'h0C, 4'd0, 4'b0101, 0, -1);
        burst(0, 32'h0C, 4'd0, 4'h0, 0, -1);
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
        burst(1, 32'h30, 4'd3, 4'hF, 1, -1);
        burst(0, 32'h30, 4'd3, 4'h0, 0, -1);
        burst(0, 32'h40, 4'd3, 4'h0, 0, 1);
        burst(0, 32'h40, 4'd3, 4'h0, 0, -1);
        for (int k = 0; k < 40; k++) begin
            for (int b = 0; b < 16; b++) wbuf[b] = $urandom;
            wr = 1'($urandom_range(0, 1));
            hold = k < 39 ? 1'($urandom_range(0, 1)) : 1'b0;
            burst(wr, $urandom, lens[$urandom_range(0, 4)], 4'($urandom_range(0, 15)), hold, -1);
        end
        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
